// File: rtl/load_store_unit_if.sv
// Bundles for the load/store unit: the execute-stage request/response channel
// and the word-wide memory bus.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both 1; resp_valid is a single-cycle pulse that cannot stall.
  modport master (
    output req_valid, is_store, funct3, addr, wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, is_store, funct3, addr, wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes width/alignment, issues one word access,
// extends load data and reports ok / misaligned / timeout / illegal.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        store_q, store_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic        illegal, misaligned;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [3:0]  st_strb;
  logic [31:0] st_data;

  // Illegal takes priority, so misalignment only matters for legal codes.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (req.funct3)
      3'b000: begin
      end
      3'b001: misaligned = req.addr[0];
      3'b010: misaligned = |req.addr[1:0];
      3'b100: illegal = req.is_store;
      3'b101: begin
        illegal    = req.is_store;
        misaligned = req.addr[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    lane_byte = mem.mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0: lane_byte = mem.mem_rdata[7:0];
      2'd1: lane_byte = mem.mem_rdata[15:8];
      2'd2: lane_byte = mem.mem_rdata[23:16];
      2'd3: lane_byte = mem.mem_rdata[31:24];
      default: lane_byte = mem.mem_rdata[7:0];
    endcase
    lane_half = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_ext = {24'd0, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_ext = {16'd0, lane_half};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  always_comb begin
    case (f3_q)
      3'b000: begin
        st_strb = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        st_strb = 4'b0011 << addr_q[1:0];
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          store_d = req.is_store;
          f3_d    = req.funct3;
          addr_d  = req.addr;
          wdata_d = req.wdata;
          rdata_d = 32'd0;
          cnt_d   = 8'd0;
          if (illegal) begin
            err_d   = ERR_ILL;
            state_d = RESP;
          end else if (misaligned) begin
            err_d   = ERR_MIS;
            state_d = RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // An ack in the last counted cycle still completes normally.
        if (mem.mem_ack) begin
          rdata_d = store_q ? 32'd0 : load_ext;
          err_d   = ERR_OK;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'd0;
          err_d   = ERR_TMO;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      store_q <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus and response outputs are gated by state, so reset alone zeroes them.
  assign mem.mem_req    = (state_q == REQ);
  assign mem.mem_we     = (state_q == REQ) && store_q;
  assign mem.mem_addr   = (state_q == REQ) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem.mem_wstrb  = ((state_q == REQ) && store_q) ? st_strb : 4'd0;
  assign mem.mem_wdata  = ((state_q == REQ) && store_q) ? st_data : 32'd0;

  assign req.req_ready  = (state_q == IDLE) && !rst;
  assign req.resp_valid = (state_q == RESP);
  assign req.resp_err   = (state_q == RESP) ? err_q : ERR_OK;
  assign req.resp_rdata = (state_q == RESP) ? rdata_q : 32'd0;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against an arithmetic
// model of RV32I load/store behaviour.
module tb_load_store_unit;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_cmp = 0;
  int         n_fail = 0;

  lsu_req_if rq ();
  lsu_mem_if mm ();

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (rq.slave),
    .mem         (mm.master),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 2'd3;
    if (st && (f3 == 4 || f3 == 5)) return 2'd3;
    if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 2'd1;
    if (f3 == 2 && (a % 4 != 0)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 0) return 4'(1 << (a % 4));
    if (f3 == 1) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 0) return (wd & 32'hFF) * 32'h0101_0101;
    if (f3 == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  // ack_at: REQ cycle index carrying mem_ack; TIMEOUT or more means never.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
    logic [1:0]  err;
    logic [31:0] exp_rd;
    bit          acked;
    err = model_err(st, f3, a);
    acked = 0;
    check("ready_before_accept", rq.req_ready, 1);
    rq.req_valid = 1'b1;
    rq.is_store  = st;
    rq.funct3    = f3;
    rq.addr      = a;
    rq.wdata     = wd;
    mm.mem_ack   = 1'($urandom_range(0, 1));
    step();
    rq.req_valid = 1'b0;
    rq.is_store  = 1'($urandom_range(0, 1));
    rq.funct3    = 3'($urandom_range(0, 7));
    rq.addr      = $urandom;
    rq.wdata     = $urandom;
    mm.mem_ack   = 1'b0;
    if (err != 2'd0) begin
      check("err_no_mem_req", mm.mem_req, 0);
      check("err_resp_valid", rq.resp_valid, 1);
      check("err_code", rq.resp_err, err);
      check("err_rdata", rq.resp_rdata, 0);
      check("err_ready_low", rq.req_ready, 0);
    end else begin
      for (int k = 0; k < TIMEOUT; k++) begin
        check("mem_req_held", mm.mem_req, 1);
        check("mem_addr", mm.mem_addr, a & 32'hFFFF_FFFC);
        check("mem_we", mm.mem_we, st);
        check("mem_wstrb", mm.mem_wstrb, st ? model_strb(f3, a) : 4'd0);
        check("mem_wdata", mm.mem_wdata, st ? model_wdata(f3, wd) : 32'd0);
        check("no_early_resp", rq.resp_valid, 0);
        mm.mem_ack   = (k == ack_at);
        mm.mem_rdata = (k == ack_at) ? rd : $urandom;
        step();
        mm.mem_ack   = 1'($urandom_range(0, 1));
        mm.mem_rdata = $urandom;
        if (k == ack_at) begin
          acked = 1;
          break;
        end
      end
      exp_rd = (st || !acked) ? 32'd0 : model_load(f3, a, rd);
      check("resp_valid", rq.resp_valid, 1);
      check("resp_err", rq.resp_err, acked ? 2'd0 : 2'd2);
      check("resp_rdata", rq.resp_rdata, exp_rd);
      check("mem_req_dropped", mm.mem_req, 0);
    end
    step();
    mm.mem_ack = 1'b0;
    check("resp_pulse_end", rq.resp_valid, 0);
    check("ready_after_resp", rq.req_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    rq.req_valid = 1'b0;
    rq.is_store  = 1'b0;
    rq.funct3    = 3'd0;
    rq.addr      = 32'd0;
    rq.wdata     = 32'd0;
    mm.mem_ack   = 1'b0;
    mm.mem_rdata = 32'd0;
    step();
    step();
    check("rst_ready", rq.req_ready, 0);
    check("rst_mem_req", mm.mem_req, 0);
    check("rst_mem_we", mm.mem_we, 0);
    check("rst_mem_addr", mm.mem_addr, 0);
    check("rst_mem_wstrb", mm.mem_wstrb, 0);
    check("rst_mem_wdata", mm.mem_wdata, 0);
    check("rst_resp_valid", rq.resp_valid, 0);
    check("rst_resp_rdata", rq.resp_rdata, 0);
    check("rst_resp_err", rq.resp_err, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", rq.req_ready, 1);

    // Directed cases
    run_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0);
    run_txn(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 2);
    run_txn(1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 0);
    run_txn(1'b0, 3'b011, 32'h0000_0006, 32'h0, 32'h0, 0);
    run_txn(1'b0, 3'b101, 32'h0000_0010, 32'h0, 32'h0, TIMEOUT + 5);
    run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1);
    run_txn(1'b1, 3'b000, 32'h0000_0301, 32'h0000_005A, 32'h0, 1);
    run_txn(1'b1, 3'b100, 32'h0000_0400, 32'h0, 32'h0, 0);
    run_txn(1'b0, 3'b001, 32'h0000_0502, 32'h0, 32'h1234_8001, 3);

    // Reset in the third REQ cycle of an LBU aborts it
    check("abort_ready", rq.req_ready, 1);
    rq.req_valid = 1'b1;
    rq.is_store  = 1'b0;
    rq.funct3    = 3'b100;
    rq.addr      = 32'h0000_0044;
    step();
    rq.req_valid = 1'b0;
    mm.mem_ack   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("abort_mem_req", mm.mem_req, 1);
      step();
    end
    check("abort_mem_req_3rd", mm.mem_req, 1);
    rst = 1'b1;
    #1;
    check("abort_ready_in_rst", rq.req_ready, 0);
    step();
    rst = 1'b0;
    #1;
    check("abort_mem_req_low", mm.mem_req, 0);
    check("abort_no_resp", rq.resp_valid, 0);
    check("abort_ready_back", rq.req_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_still_no_resp", rq.resp_valid, 0);
    end

    // Randomized transactions
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra,
              $urandom, $urandom, $urandom_range(0, TIMEOUT + 3));
      if ($urandom_range(0, 2) == 0) begin
        mm.mem_ack = 1'b1;
        step();
        mm.mem_ack = 1'b0;
        check("idle_ack_ignored", mm.mem_req, 0);
        check("idle_ack_no_resp", rq.resp_valid, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
